// File: rtl/count_toggle_bank.sv
// count_toggle_bank
//
// A bank of NUM_CH independent count-and-toggle channels for the memory
// game's LEDs and tone enables. Each channel divides i_clk by a runtime
// limit and produces a square wave (TOGGLE), a one-cycle tick (PULSE) or
// a finite burst of blinks with a completion pulse (BURST).
//
// Build option:
//   COUNT_TOGGLE_BANK_BURST_EN  defined   -> BURST mode (mode 2) compiled in
//                               undefined -> mode 2 behaves as TOGGLE,
//                                            i_start/i_burst ignored,
//                                            o_busy/o_done stay 0
//
// Parameters:
//   NUM_CH   number of channels
//   CNT_W    width of each period counter / limit field
//   BURST_W  width of each burst-count field
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_en     per-channel count enable (low freezes the channel)
//   i_clr    per-channel synchronous clear
//   i_mode   per-channel mode, ch k at [2k+1:2k] (0 toggle, 1 pulse,
//            2 burst, 3 toggle)
//   i_limit  per-channel period in enabled cycles, ch k at [CNT_W*k +: CNT_W]
//   i_start  per-channel burst start pulse
//   i_burst  per-channel blink count, sampled with i_start
//   o_out    per-channel registered output
//   o_busy   channel is running a burst
//   o_done   one-cycle pulse when a burst completes
//
// Per-channel FSM (only meaningful in BURST mode):
//   state   | meaning
//   IDLE    | no burst in progress; counter frozen while in BURST mode
//   RUN     | burst in progress; each tick flips o_out and uses one toggle

module count_toggle_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 24,
   parameter int BURST_W = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_CH-1:0]         i_en,
   input  logic [NUM_CH-1:0]         i_clr,
   input  logic [2*NUM_CH-1:0]       i_mode,
   input  logic [CNT_W*NUM_CH-1:0]   i_limit,
   input  logic [NUM_CH-1:0]         i_start,
   input  logic [BURST_W*NUM_CH-1:0] i_burst,
   output logic [NUM_CH-1:0]         o_out,
   output logic [NUM_CH-1:0]         o_busy,
   output logic [NUM_CH-1:0]         o_done
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0]   lim;
      logic [1:0]         mode;
      logic [BURST_W-1:0] blinks;
      logic               is_burst;

      state_t             r_state, nxt_state;
      logic [CNT_W-1:0]   r_count, nxt_count;
      logic [BURST_W:0]   r_rem, nxt_rem;
      logic               r_out, nxt_out;
      logic               r_done, nxt_done;
      logic               active;
      logic               tick;

      assign lim    = i_limit[CNT_W*g +: CNT_W];
      assign mode   = i_mode[2*g +: 2];
      assign blinks = i_burst[BURST_W*g +: BURST_W];

`ifdef COUNT_TOGGLE_BANK_BURST_EN
      assign is_burst = (mode == 2'd2);
`else
      // With bursts compiled out the burst path below is never taken, so
      // r_state stays IDLE and r_done stays 0.
      assign is_burst = 1'b0;
`endif

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_rem   <= '0;
            r_out   <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            r_state <= nxt_state;
            r_count <= nxt_count;
            r_rem   <= nxt_rem;
            r_out   <= nxt_out;
            r_done  <= nxt_done;
         end
      end

      always_comb begin
         nxt_state = r_state;
         nxt_count = r_count;
         nxt_rem   = r_rem;
         nxt_out   = r_out;
         nxt_done  = 1'b0;

         // In BURST mode the counter only advances while a burst runs.
         active = i_en[g] && (!is_burst || (r_state == ST_RUN));
         // >= rather than == so a limit lowered below the current count
         // still ticks on the next enabled cycle instead of wrapping.
         tick   = active && (lim != '0) && (r_count >= (lim - CNT_W'(1)));

         if (i_clr[g]) begin
            nxt_state = ST_IDLE;
            nxt_count = '0;
            nxt_rem   = '0;
            nxt_out   = 1'b0;
         end else if (is_burst && i_start[g]) begin
            nxt_count = '0;
            nxt_out   = 1'b0;
            nxt_rem   = {blinks, 1'b0};
            if (blinks == '0) begin
               nxt_state = ST_IDLE;
               nxt_done  = 1'b1;
            end else begin
               nxt_state = ST_RUN;
            end
         end else begin
            if (!is_burst) begin
               nxt_state = ST_IDLE;
               nxt_rem   = '0;
            end

            if (active) begin
               if (lim == '0 || tick) nxt_count = '0;
               else                   nxt_count = r_count + CNT_W'(1);
            end

            case (mode)
               2'd1: nxt_out = tick;
               2'd2: begin
                  if (tick) begin
                     if (is_burst && (r_rem <= (BURST_W+1)'(1))) begin
                        nxt_out   = 1'b0;
                        nxt_rem   = '0;
                        nxt_state = ST_IDLE;
                        nxt_done  = 1'b1;
                     end else begin
                        nxt_out = ~r_out;
                        if (is_burst) nxt_rem = r_rem - (BURST_W+1)'(1);
                     end
                  end
               end
               default: begin
                  if (tick) nxt_out = ~r_out;
               end
            endcase
         end
      end

      always_comb begin
         o_out[g]  = r_out;
         o_busy[g] = (r_state == ST_RUN);
         o_done[g] = r_done;
      end
   end

endmodule

// File: tb/tb_count_toggle_bank.sv
module tb_count_toggle_bank;
   localparam int NCH = 4;
   localparam int CW  = 24;
   localparam int BW  = 4;

   logic              clk;
   logic              rst_n;
   logic [NCH-1:0]    en, clr, start;
   logic [2*NCH-1:0]  mode;
   logic [CW*NCH-1:0] limit;
   logic [BW*NCH-1:0] burst_n;
   logic [NCH-1:0]    o_out, o_busy, o_done;

   int total = 0;
   int bad   = 0;
   bit burst_en;

   // behavioural model state: period position, output level, toggles left,
   // burst running, done pulse
   int m_cnt[NCH], m_out[NCH], m_rem[NCH], m_run[NCH], m_done[NCH];

   count_toggle_bank #(.NUM_CH(NCH), .CNT_W(CW), .BURST_W(BW)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_en   (en),
      .i_clr  (clr),
      .i_mode (mode),
      .i_limit(limit),
      .i_start(start),
      .i_burst(burst_n),
      .o_out  (o_out),
      .o_busy (o_busy),
      .o_done (o_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int c, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, c, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0; m_out[c] = 0; m_rem[c] = 0; m_run[c] = 0; m_done[c] = 0;
      end
   endtask

   // One rising edge of the specification's per-channel rules.
   task automatic model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         int  lim_v  = int'(limit[CW*c +: CW]);
         int  md     = int'(mode[2*c +: 2]);
         int  nb     = int'(burst_n[BW*c +: BW]);
         bit  act, tk;
         if (md == 3) md = 0;
         if (md == 2 && !burst_en) md = 0;
         m_done[c] = 0;
         if (clr[c]) begin
            m_cnt[c] = 0; m_out[c] = 0; m_rem[c] = 0; m_run[c] = 0;
         end else if (md == 2 && start[c]) begin
            m_cnt[c]  = 0;
            m_out[c]  = 0;
            m_rem[c]  = 2 * nb;
            m_run[c]  = (nb != 0);
            m_done[c] = (nb == 0);
         end else begin
            if (md != 2) begin
               m_run[c] = 0;
               m_rem[c] = 0;
            end
            act = en[c] && (md != 2 || m_run[c] != 0);
            tk  = act && lim_v != 0 && m_cnt[c] >= lim_v - 1;
            if (act) m_cnt[c] = (lim_v == 0 || tk) ? 0 : m_cnt[c] + 1;
            if (md == 1) begin
               m_out[c] = tk;
            end else if (tk) begin
               m_out[c] = 1 - m_out[c];
               if (md == 2) begin
                  m_rem[c]--;
                  if (m_rem[c] <= 0) begin
                     m_out[c] = 0; m_rem[c] = 0; m_run[c] = 0; m_done[c] = 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic compare();
      for (int c = 0; c < NCH; c++) begin
         check("out",  c, int'(o_out[c]),  m_out[c]);
         check("busy", c, int'(o_busy[c]), m_run[c]);
         check("done", c, int'(o_done[c]), m_done[c]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic set_lim(input int c, input int v);
      limit[CW*c +: CW] = CW'(v);
   endtask

   task automatic set_mode(input int c, input int v);
      mode[2*c +: 2] = 2'(v);
   endtask

   task automatic set_burst(input int c, input int v);
      burst_n[BW*c +: BW] = BW'(v);
   endtask

   initial begin
      burst_en = 1'b0;
`ifdef COUNT_TOGGLE_BANK_BURST_EN
      burst_en = 1'b1;
`endif
      rst_n = 1'b0; en = '1; clr = '0; start = '0; mode = '0; limit = '0; burst_n = '0;
      set_lim(0, 5); set_lim(1, 3); set_lim(2, 4); set_lim(3, 2);
      model_reset();

      // reset held with everything enabled
      for (int k = 0; k < 3; k++) step();
      check("rst_out",  0, int'(o_out),  0);
      check("rst_busy", 0, int'(o_busy), 0);
      check("rst_done", 0, int'(o_done), 0);
      rst_n = 1'b1;
      en    = 4'b0011;

      // TOGGLE ch0 L=5 and ch1 L=3 concurrently
      for (int k = 1; k <= 30; k++) begin
         step();
         check("tog5", 0, int'(o_out[0]), (k / 5) % 2);
         check("tog3", 1, int'(o_out[1]), (k / 3) % 2);
      end

      // PULSE ch2 L=4, enable dropped on edges 7 and 8
      set_mode(2, 1);
      for (int k = 1; k <= 16; k++) begin
         en[2] = !(k == 7 || k == 8);
         step();
         check("pulse", 2, int'(o_out[2]), (k == 4 || k == 10 || k == 14) ? 1 : 0);
      end

      // limit 8 lowered to 2 when the count is 6
      clr[0] = 1'b1; step(); clr[0] = 1'b0;
      set_lim(0, 8);
      for (int k = 0; k < 6; k++) step();
      check("low_pre", 0, int'(o_out[0]), 0);
      set_lim(0, 2);
      step();
      check("low_tick", 0, int'(o_out[0]), 1);

      // limit 0 freezes the output
      set_lim(0, 0);
      for (int k = 0; k < 10; k++) begin
         step();
         check("lim0", 0, int'(o_out[0]), 1);
      end

      // channel 3: burst scenarios (or toggle behaviour when compiled out)
      en[3] = 1'b1;
      set_mode(3, 2);
      set_lim(3, 2);
      clr[3] = 1'b1; step(); clr[3] = 1'b0;
      if (burst_en) begin
         set_burst(3, 3); start[3] = 1'b1; step(); start[3] = 1'b0;
         check("b_busy0", 3, int'(o_busy[3]), 1);
         for (int k = 1; k <= 14; k++) begin
            step();
            check("b_busy", 3, int'(o_busy[3]), k <= 11 ? 1 : 0);
            check("b_done", 3, int'(o_done[3]), k == 12 ? 1 : 0);
            check("b_out",  3, int'(o_out[3]),  k < 12 ? (k / 2) % 2 : 0);
         end
         set_burst(3, 0); start[3] = 1'b1; step(); start[3] = 1'b0;
         check("b0_done", 3, int'(o_done[3]), 1);
         check("b0_busy", 3, int'(o_busy[3]), 0);
         check("b0_out",  3, int'(o_out[3]),  0);
         step();
         check("b0_done2", 3, int'(o_done[3]), 0);
         set_burst(3, 2); clr[3] = 1'b1; start[3] = 1'b1; step();
         clr[3] = 1'b0; start[3] = 1'b0;
         check("cs_busy", 3, int'(o_busy[3]), 0);
         check("cs_done", 3, int'(o_done[3]), 0);
         step();
         check("cs_done2", 3, int'(o_done[3]), 0);
         // first burst would finish 4 edges after the restart; only the
         // restarted one (8 edges) may pulse o_done
         start[3] = 1'b1; step(); start[3] = 1'b0;
         for (int k = 0; k < 3; k++) step();
         start[3] = 1'b1; step(); start[3] = 1'b0;
         for (int k = 1; k <= 10; k++) begin
            step();
            check("rs_done", 3, int'(o_done[3]), k == 8 ? 1 : 0);
            check("rs_busy", 3, int'(o_busy[3]), k < 8 ? 1 : 0);
         end
      end else begin
         set_burst(3, 3);
         for (int k = 1; k <= 12; k++) begin
            start[3] = (k == 1);
            step();
            check("m2_out",  3, int'(o_out[3]),  (k / 2) % 2);
            check("m2_busy", 3, int'(o_busy[3]), 0);
            check("m2_done", 3, int'(o_done[3]), 0);
         end
         start[3] = 1'b0;
      end

      // randomized traffic against the model
      en = '1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < NCH; c++) begin
            en[c]    = ($urandom % 8) != 0;
            clr[c]   = ($urandom % 64) == 0;
            start[c] = ($urandom % 16) == 0;
            if ($urandom % 50 == 0) set_mode(c, int'($urandom % 4));
            if ($urandom % 40 == 0) set_lim(c, int'($urandom_range(0, 6)));
            if (start[c]) set_burst(c, int'($urandom % 4));
         end
         if ($urandom % 1000 == 0) begin
            rst_n = 1'b0;
            model_reset();
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
